seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised multiplexed seven-segment scanner driving N_DIG common-select digits from a packed hex word. Adds per-digit blanking and decimal points, 16-level brightness with a ghost-guard blank sub-slot, and a frame-synchronous double-buffered load. It sits between the application registers and the board's `sel`/`dig` pins. It replaces free-running, reset-less scanners with a deterministic, fully reset design.

## Interface
- `N_DIG`, 6: number of digits, 1..8.
- `DIV`, 50000: clk cycles per scan tick, ≥2.
- `SEG_ACT_LOW`, 1: 1 means segment lines are active-low (common-anode).
- `SEL_ACT_LOW`, 1: 1 means digit selects are active-low.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in 4*N_DIG: nibble i = `data_in[4i+3:4i]`, shown on digit i.
- `blank_in` in N_DIG: 1 blanks digit i.
- `dp_in` in N_DIG: 1 lights the decimal point of digit i.
- `bright` in 4: on-time in sub-slots, 0 = dark, 15 = maximum.
- `load` in 1: single-cycle capture strobe for data_in/blank_in/dp_in/bright.
- `pending` out 1: a captured set is waiting for the frame boundary.
- `frame_start` out 1: one-cycle pulse when the digit-0 slot begins.
- `sel` out N_DIG: digit selects, one-hot-active or all inactive.
- `dig` out 8: `dig[7]` = dp, `dig[6:0]` = g..a.

## Operation
- Prescaler counts 0..DIV-1 and wraps. `tick` asserts in the wrap cycle.
- Scan state is `(idx, sub)`: `sub` 0..15, `idx` 0..N_DIG-1. On each tick `sub` increments. When `sub` wraps from 15 to 0, `idx` increments, wrapping from N_DIG-1 to 0.
- Sub-slot 0 is the ghost guard: all selects are inactive.
- Digit `idx` is driven when 1 ≤ `sub` ≤ active bright. bright=15 gives 15/16 duty. bright=0 keeps the digit dark.
- A digit that is driven but blanked has its select active and its segments all off, dp included.
- Hex decode, active-high before polarity: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71. dp is OR'd into bit 7.
- Polarity is applied last. When a param is 1, the corresponding output is inverted.
- Double buffering:
  - `load` copies the inputs into a shadow register and sets `pending`.
  - At a frame boundary (tick where `idx` wraps N_DIG-1 to 0), if `pending` is set, the shadow copies to the active register and `pending` clears.
  - `load` while `pending` is set overwrites the shadow; the last load wins.
  - `load` in the boundary cycle: the boundary commits the old shadow contents, the new values enter the shadow, and `pending` stays 1.
- Reset values:
  - `sel` and `dig` all inactive (0x3F/0xFF for active-low defaults).
  - Active blank all 1, active bright 0, data 0, dp 0.
  - `pending`=0, `frame_start`=0, `idx`=0, `sub`=0, prescaler 0.
- Reset mid-frame returns to the reset values immediately and asynchronously. Any shadow contents are discarded.

## Timing
- `sel`, `dig` and `frame_start` are registered, with one clk of latency from the `(idx, sub)` update.
- Tick period is DIV clk. Slot is 16·DIV. Frame is 16·DIV·N_DIG.
- The first tick comes DIV cycles after rst_n deasserts.
- `frame_start` pulses in the clk after the boundary tick, aligned with the first `sel` update of digit 0, which is always the guard, inactive.
- `pending` rises the clk after `load` and falls the clk after the committing boundary tick.
- The newly committed values are visible from sub-slot 1 of digit 0.
- Inputs are sampled only on the `load` cycle; changes in between have no effect.

## Structure
- Package `seg_pkg`:
  - Hex-to-segment function and table constants.
  - `SEG_OFF` constant.
  - Sub-slot count 16 as `SUB_SLOTS`.
- Sub-module `seg_hex_decode`: a combinational nibble+dp+blank to 8-bit active-high segments. It is instantiated once on the muxed active nibble.
- Everything else (prescaler, scan counters, shadow/active registers, output registers) lives in `seg_scan_ctrl`.

## Test plan
All scenarios use DIV=4, N_DIG=6, default polarity.
- Reset hold: assert rst_n=0 mid-scan → `sel`=6'h3F and `dig`=8'hFF asynchronously. After release there is no digit active until a load commits.
- Load 24'h12_34_56, blank 0, dp 0, bright 15 → `pending` goes to 1.
  - After the boundary it returns to 0.
  - The digit-0 slot shows `sel`=6'h3E with `dig`=~8'h7D ("6") for sub-slots 1..15, and all inactive during sub 0.
- bright=4 → each digit is active for exactly 16 clk (sub 1..4) of every 64-clk slot.
- blank_in=6'b000010 with dp_in=6'b000010 → digit 1 select toggles but `dig`=8'hFF. dp_in=6'b000001 → digit 0 `dig[7]`=0.
- Two loads (A then B) within one frame → only B is displayed after the boundary; A never appears.
- `load` in the exact boundary cycle → the old shadow commits, `pending` stays 1, and the new data appears after the next boundary. `frame_start` pulses once per 384 clk.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scanner.
package seg_pkg;

  // Sub-slots per digit slot; sub-slot 0 is the ghost-guard blank.
  localparam int unsigned SUB_SLOTS = 16;

  // Active-high "all segments off" pattern (before polarity is applied).
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Segment patterns g..a for hex digits 0..F, active-high.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble + decimal point + blank to 8-bit active-high segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Blank overrides both the glyph and the decimal point.
  always_comb begin
    seg = SEG_OFF;
    if (!blank) seg = {dp, hex_to_seg(nibble)};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaler, (idx, sub) scan counters,
// double-buffered display set committed at frame boundaries, registered pins.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIG       = 6,
  parameter int unsigned DIV         = 50000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          SEL_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] data_in,
  input  logic [N_DIG-1:0]   blank_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [3:0]         bright,
  input  logic               load,
  output logic               pending,
  output logic               frame_start,
  output logic [N_DIG-1:0]   sel,
  output logic [7:0]         dig
);

  localparam int unsigned      IDX_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned      CNT_W    = $clog2(DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]       SUB_LAST = 4'(SUB_SLOTS - 1);
  localparam logic [N_DIG-1:0] SEL_INV  = {N_DIG{SEL_ACT_LOW}};
  localparam logic [7:0]       SEG_INV  = {8{SEG_ACT_LOW}};

  logic [CNT_W-1:0]   pre_cnt;
  logic               tick;
  logic               tick_q;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         sub;
  logic               boundary;

  logic [4*N_DIG-1:0] sh_data,  act_data;
  logic [N_DIG-1:0]   sh_blank, act_blank;
  logic [N_DIG-1:0]   sh_dp,    act_dp;
  logic [3:0]         sh_bright, act_bright;

  logic [4*N_DIG-1:0] data_shifted;
  logic [3:0]         cur_nib;
  logic               cur_blank;
  logic               cur_dp;
  logic               drive;
  logic [7:0]         dec_seg;
  logic [N_DIG-1:0]   sel_hi;
  logic [7:0]         seg_hi;

  assign tick     = (pre_cnt == CNT_LAST);
  assign boundary = tick && (sub == SUB_LAST) && (idx == IDX_LAST);

  // Prescaler: free-running 0..DIV-1, tick in the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Scan counters: sub advances every tick, idx advances when sub wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub <= '0;
      idx <= '0;
    end else if (tick) begin
      sub <= sub + 1'b1;
      if (sub == SUB_LAST) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: load fills the shadow, a frame boundary commits it.
  // A load coinciding with the boundary commits the old shadow and keeps pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data    <= '0;
      sh_blank   <= '0;
      sh_dp      <= '0;
      sh_bright  <= '0;
      act_data   <= '0;
      act_blank  <= '1;
      act_dp     <= '0;
      act_bright <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        sh_data   <= data_in;
        sh_blank  <= blank_in;
        sh_dp     <= dp_in;
        sh_bright <= bright;
      end
      if (boundary && pending) begin
        act_data   <= sh_data;
        act_blank  <= sh_blank;
        act_dp     <= sh_dp;
        act_bright <= sh_bright;
      end
      pending <= load | (pending & ~boundary);
    end
  end

  // Select the current digit's nibble and flags from the active set.
  always_comb begin
    data_shifted = act_data >> {idx, 2'b00};
    cur_nib      = data_shifted[3:0];
    cur_blank    = act_blank[idx];
    cur_dp       = act_dp[idx];
  end

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

  // Digit on only in sub-slots 1..bright; sub-slot 0 is always the guard.
  always_comb begin
    drive  = (sub != 4'd0) && (sub <= act_bright);
    sel_hi = '0;
    seg_hi = SEG_OFF;
    if (drive) begin
      sel_hi[idx] = 1'b1;
      seg_hi      = dec_seg;
    end
  end

  // Output registers: polarity applied last; frame_start marks the first
  // output update after idx returns to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= SEL_INV;
      dig         <= SEG_OFF ^ SEG_INV;
      tick_q      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel_hi ^ SEL_INV;
      dig         <= seg_hi ^ SEG_INV;
      tick_q      <= tick;
      frame_start <= tick_q && (idx == '0) && (sub == 4'd0);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4, N_DIG=6, active-low outputs.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data_in;
  logic [5:0]  blank_in;
  logic [5:0]  dp_in;
  logic [3:0]  bright;
  logic        load;
  logic        pending;
  logic        frame_start;
  logic [5:0]  sel;
  logic [7:0]  dig;

  int vectors = 0;
  int miscompares = 0;

  // Expected active display set.
  logic [23:0] e_data;
  logic [5:0]  e_blank;
  logic [5:0]  e_dp;
  logic [3:0]  e_bright;

  logic [5:0]  cap_sel [384];
  logic [7:0]  cap_dig [384];

  localparam logic [7:0] HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  seg_scan_ctrl #(
    .N_DIG       (6),
    .DIV         (4),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .blank_in    (blank_in),
    .dp_in       (dp_in),
    .bright      (bright),
    .load        (load),
    .pending     (pending),
    .frame_start (frame_start),
    .sel         (sel),
    .dig         (dig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_sel(input int t);
    int d = t / 64;
    int s = (t / 4) % 16;
    if (s >= 1 && s <= int'(e_bright)) return ~(6'b1 << d);
    return 6'h3F;
  endfunction

  function automatic logic [7:0] m_dig(input int t);
    int d = t / 64;
    int s = (t / 4) % 16;
    logic [23:0] sh;
    logic [3:0]  nib;
    logic [7:0]  seg;
    sh  = e_data >> (4 * d);
    nib = sh[3:0];
    seg = e_blank[d] ? 8'h00 : {e_dp[d], HEX[nib][6:0]};
    if (s >= 1 && s <= int'(e_bright)) return ~seg;
    return 8'hFF;
  endfunction

  // Pulse load for one cycle, then scramble inputs (they must be ignored).
  task automatic do_load(input logic [23:0] d, input logic [5:0] b,
                         input logic [5:0] p, input logic [3:0] br);
    data_in  = d;
    blank_in = b;
    dp_in    = p;
    bright   = br;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    data_in  = 24'hFEDCBA;
    blank_in = 6'h2A;
    dp_in    = 6'h15;
    bright   = 4'h7;
    chk("pending_after_load", 32'(pending), 32'd1);
  endtask

  // Advance to the next frame_start (bounded); reports cycles waited and any lit digit.
  task automatic wait_fs(output int n, output logic lit);
    n   = 0;
    lit = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (sel !== 6'h3F) lit = 1'b1;
    end while (frame_start !== 1'b1 && n < 500);
    chk("frame_start_wait_bound", 32'(frame_start), 32'd1);
  endtask

  // Check one whole frame from a frame_start sample point against the model.
  task automatic check_frame(input string tag);
    for (int t = 0; t < 384; t++) begin
      cap_sel[t] = sel;
      cap_dig[t] = dig;
      chk($sformatf("%s_sel_t%0d", tag, t), 32'(sel), 32'(m_sel(t)));
      chk($sformatf("%s_dig_t%0d", tag, t), 32'(dig), 32'(m_dig(t)));
      chk($sformatf("%s_fs_t%0d", tag, t), 32'(frame_start), (t == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk({tag, "_fs_period"}, 32'(frame_start), 32'd1);
  endtask

  initial begin
    int   n;
    int   cnt;
    logic lit;

    rst_n    = 1'b0;
    data_in  = '0;
    blank_in = '0;
    dp_in    = '0;
    bright   = '0;
    load     = 1'b0;
    e_data   = '0;
    e_blank  = '1;
    e_dp     = '0;
    e_bright = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'h3F);
    chk("rst_dig", 32'(dig), 32'hFF);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1;

    // First frame_start: 96 ticks of 4 clk, plus one clk of output latency
    wait_fs(n, lit);
    chk("first_fs_latency", 32'(n), 32'd385);
    chk("dark_after_reset", 32'(lit), 32'd0);

    // Basic load, bright 15
    do_load(24'h123456, 6'h00, 6'h00, 4'd15);
    wait_fs(n, lit);
    chk("first_commit_wait", 32'(n), 32'd383);
    chk("pending_cleared", 32'(pending), 32'd0);
    e_data = 24'h123456; e_blank = 6'h00; e_dp = 6'h00; e_bright = 4'd15;
    check_frame("b15");
    chk("b15_guard_sel", 32'(cap_sel[0]), 32'h3F);
    chk("b15_guard_dig", 32'(cap_dig[0]), 32'hFF);
    chk("b15_d0_sel", 32'(cap_sel[4]), 32'h3E);
    chk("b15_d0_dig", 32'(cap_dig[4]), 32'h82);
    chk("b15_d0_last_sel", 32'(cap_sel[63]), 32'h3E);
    chk("b15_d1_guard_sel", 32'(cap_sel[64]), 32'h3F);
    chk("b15_d1_sel", 32'(cap_sel[68]), 32'h3D);
    chk("b15_d1_dig", 32'(cap_dig[68]), 32'h92);

    // Brightness 4: 16 clk on per 64 clk slot
    do_load(24'h123456, 6'h00, 6'h00, 4'd4);
    wait_fs(n, lit);
    e_bright = 4'd4;
    check_frame("b4");
    chk("b4_sub4_sel", 32'(cap_sel[16]), 32'h3E);
    chk("b4_sub5_sel", 32'(cap_sel[20]), 32'h3F);
    for (int d = 0; d < 6; d++) begin
      cnt = 0;
      for (int t = 64 * d; t < 64 * d + 64; t++) if (cap_sel[t] !== 6'h3F) cnt++;
      chk($sformatf("b4_on_clks_d%0d", d), 32'(cnt), 32'd16);
    end

    // Blank digit 1 with dp set, dp on digit 0
    do_load(24'h123456, 6'b000010, 6'b000011, 4'd15);
    wait_fs(n, lit);
    e_blank = 6'b000010; e_dp = 6'b000011; e_bright = 4'd15;
    check_frame("blank");
    chk("blank_d0_dp_dig", 32'(cap_dig[4]), 32'h02);
    chk("blank_d1_sel", 32'(cap_sel[68]), 32'h3D);
    chk("blank_d1_dig", 32'(cap_dig[68]), 32'hFF);

    // Two loads in one frame: last wins
    do_load(24'hABCDEF, 6'h00, 6'h00, 4'd15);
    repeat (9) @(negedge clk);
    do_load(24'h987650, 6'h00, 6'h00, 4'd15);
    wait_fs(n, lit);
    chk("twoload_pending_cleared", 32'(pending), 32'd0);
    e_data = 24'h987650; e_blank = 6'h00; e_dp = 6'h00; e_bright = 4'd15;
    check_frame("twoload");
    chk("twoload_d0_dig", 32'(cap_dig[4]), 32'hC0);

    // Load exactly in the boundary tick cycle
    do_load(24'h111111, 6'h00, 6'h00, 4'd8);
    repeat (381) @(negedge clk);
    do_load(24'h222222, 6'h00, 6'h00, 4'd15);
    @(negedge clk);
    chk("bnd_fs", 32'(frame_start), 32'd1);
    chk("bnd_pending_kept", 32'(pending), 32'd1);
    e_data = 24'h111111; e_bright = 4'd8;
    check_frame("bnd_old");
    chk("bnd_old_d0_dig", 32'(cap_dig[4]), 32'hF9);
    chk("bnd_old_sub8_sel", 32'(cap_sel[32]), 32'h3E);
    chk("bnd_old_sub9_sel", 32'(cap_sel[36]), 32'h3F);
    chk("bnd_new_pending_cleared", 32'(pending), 32'd0);
    e_data = 24'h222222; e_bright = 4'd15;
    check_frame("bnd_new");
    chk("bnd_new_d0_dig", 32'(cap_dig[4]), 32'hA4);

    // Asynchronous reset mid-scan discards a pending shadow
    do_load(24'h777777, 6'h00, 6'h00, 4'd15);
    repeat (69) @(negedge clk);
    chk("pre_rst_sel", 32'(sel), 32'h3D);
    chk("pre_rst_dig", 32'(dig), 32'hA4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 32'h3F);
    chk("async_rst_dig", 32'(dig), 32'hFF);
    chk("async_rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n, lit);
    chk("rst2_fs_latency", 32'(n), 32'd385);
    chk("rst2_dark", 32'(lit), 32'd0);
    chk("rst2_pending", 32'(pending), 32'd0);
    e_data = '0; e_blank = '1; e_dp = '0; e_bright = 4'd0;
    check_frame("rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
